// File: rtl/write_back_buffer.sv
// write_back_buffer: DEPTH-entry eviction FIFO between a cache and memory.
// Read misses bypass queued lines; writes to a buffered line coalesce.
module write_back_buffer #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 32,
    parameter int OFFSET = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       read,
    input  logic                       write,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       resp,
    output logic [ADDR_W-1:0]          pmem_address,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [WIDTH-1:0]           pmem_wdata,
    input  logic [WIDTH-1:0]           pmem_rdata,
    input  logic                       pmem_resp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int TW = ADDR_W - OFFSET;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        FWD_READ,
        DRAIN,
        RESP
    } state_t;

    state_t state;

    logic [TW-1:0]    tag_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rdata_q;

    logic [TW-1:0]    line;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rel;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             full;
    logic             unused_offset;

    assign line          = address[ADDR_W-1:OFFSET];
    assign unused_offset = ^address[OFFSET-1:0];
    assign full          = (count_q == CW'(DEPTH));

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign rdata      = rdata_q;
    assign pmem_wdata = data_q[head];

    // An entry is live when its distance from head is below count.
    always_comb begin
        valid   = '0;
        rel     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel      = PW'(i) - head;
            valid[i] = {1'b0, rel} < count_q;
            if (valid[i] && (tag_q[i] == line)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count_q      <= '0;
            rdata_q      <= '0;
            resp         <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (read && hit) begin
                        rdata_q <= data_q[hit_idx];
                        resp    <= 1'b1;
                        state   <= RESP;
                    end else if (read) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= {line, {OFFSET{1'b0}}};
                        state        <= FWD_READ;
                    end else if (write && hit) begin
                        data_q[hit_idx] <= wdata;
                        resp            <= 1'b1;
                        state           <= RESP;
                    end else if (write && !full) begin
                        tag_q[tail]  <= line;
                        data_q[tail] <= wdata;
                        tail         <= tail + PW'(1);
                        count_q      <= count_q + CW'(1);
                        resp         <= 1'b1;
                        state        <= RESP;
                    end else if (write || !empty) begin
                        // Full-miss writes wait here for the head to retire.
                        pmem_write   <= 1'b1;
                        pmem_address <= {tag_q[head], {OFFSET{1'b0}}};
                        state        <= DRAIN;
                    end
                end
                FWD_READ: begin
                    if (pmem_resp) begin
                        rdata_q      <= pmem_rdata;
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                        resp         <= 1'b1;
                        state        <= RESP;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        head         <= head + PW'(1);
                        count_q      <= count_q - CW'(1);
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        state        <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// tb_write_back_buffer: directed and random scenarios against a queue model
// of the buffered lines and a backing-memory model.
`timescale 1ns/1ps
module tb_write_back_buffer;

    localparam int WIDTH  = 256;
    localparam int ADDR_W = 32;
    localparam int OFFSET = 5;
    localparam int DEPTH  = 4;
    localparam int TW     = ADDR_W - OFFSET;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WIDTH-1:0]  line_t;
    typedef struct packed {
        logic [TW-1:0] tag;
        line_t         data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    addr_t         address;
    logic          read;
    logic          write;
    line_t         wdata;
    line_t         rdata;
    logic          resp;
    addr_t         pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    line_t         pmem_wdata;
    line_t         pmem_rdata;
    logic          pmem_resp;
    logic [CW-1:0] count;
    logic          empty;

    int checks = 0;
    int errors = 0;

    ent_t  mq[$];
    line_t ref_mem[addr_t];
    line_t mem_store[addr_t];
    addr_t log_a[$];
    line_t log_d[$];
    int    wr_total = 0;
    int    rd_total = 0;
    int    mem_lat = 0;
    int    lat_cnt = 0;
    bit    stall_wr = 1'b0;

    write_back_buffer #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W),
        .OFFSET(OFFSET),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .wdata       (wdata),
        .rdata       (rdata),
        .resp        (resp),
        .pmem_address(pmem_address),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .count       (count),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    function automatic line_t mem_default(addr_t a);
        line_t v;
        for (int i = 0; i < WIDTH / 32; i++)
            v[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1));
        return v;
    endfunction

    function automatic line_t rand_line();
        line_t v;
        for (int i = 0; i < WIDTH / 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory side: latency mem_lat, writes may be held off with stall_wr.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (reset || !(pmem_read || pmem_write)) begin
                lat_cnt = 0;
            end else if (pmem_write && stall_wr) begin
                lat_cnt = lat_cnt;
            end else if (lat_cnt < mem_lat) begin
                lat_cnt++;
            end else begin
                lat_cnt   = 0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    log_a.push_back(pmem_address);
                    log_d.push_back(pmem_wdata);
                    mem_store[pmem_address] = pmem_wdata;
                    wr_total++;
                end else begin
                    pmem_rdata = mem_store.exists(pmem_address) ?
                                 mem_store[pmem_address] :
                                 mem_default(pmem_address);
                    rd_total++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1);
    end

    // Model: each memory write must retire the oldest buffered line.
    function automatic int retire();
        int    bad = 0;
        addr_t a;
        line_t d;
        while (log_a.size() > 0) begin
            a = log_a.pop_front();
            d = log_d.pop_front();
            if (mq.size() == 0) begin
                bad++;
            end else begin
                if (addr_t'({mq[0].tag, {OFFSET{1'b0}}}) !== a) bad++;
                if (mq[0].data !== d) bad++;
                ref_mem[addr_t'({mq[0].tag, {OFFSET{1'b0}}})] = mq[0].data;
                void'(mq.pop_front());
            end
        end
        return bad;
    endfunction

    function automatic bit model_has(addr_t a);
        foreach (mq[i])
            if (mq[i].tag == a[ADDR_W-1:OFFSET]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_write(addr_t a, line_t d);
        ent_t e;
        foreach (mq[i]) begin
            if (mq[i].tag == a[ADDR_W-1:OFFSET]) begin
                mq[i].data = d;
                return 0;
            end
        end
        if (mq.size() >= DEPTH) return 1;
        e.tag  = a[ADDR_W-1:OFFSET];
        e.data = d;
        mq.push_back(e);
        return 0;
    endfunction

    function automatic line_t expected_read(addr_t a);
        addr_t la;
        foreach (mq[i])
            if (mq[i].tag == a[ADDR_W-1:OFFSET]) return mq[i].data;
        la = {a[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
        if (ref_mem.exists(la)) return ref_mem[la];
        return mem_default(la);
    endfunction

    task automatic cache_write(input addr_t a, input line_t d,
                               output int lat);
        address = a;
        wdata   = d;
        write   = 1'b1;
        lat     = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp && lat < 300);
        if (!resp) lat = -1;
        write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cache_read(input addr_t a, output line_t d,
                              output int lat);
        address = a;
        read    = 1'b1;
        lat     = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp && lat < 300);
        d = rdata;
        if (!resp) lat = -1;
        read = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(output bit ok);
        int n = 0;
        while (!(empty && !pmem_write) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = empty && !pmem_write;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        read    = 1'b0;
        write   = 1'b0;
        address = '0;
        wdata   = '0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_count count=%0d empty=%b want 0/1", count, empty);
        end
        checks++;
        if ({resp, pmem_read, pmem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl resp/rd/wr=%b want 000",
                     {resp, pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== '0 || rdata !== '0 || pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h rdata=%h wdata=%h want 0",
                     pmem_address, rdata, pmem_wdata);
        end
        reset = 1'b0;
        mq.delete();
        log_a.delete();
        log_d.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_drain();
        line_t d = rand_line();
        int    lat;
        int    w0 = wr_total;
        bit    ok;
        mem_lat  = 0;
        stall_wr = 1'b0;
        cache_write(32'h1000, d, lat);
        checks++;
        if (lat !== 1 || count !== 1 || model_write(32'h1000, d) != 0) begin
            errors++;
            $display("FAIL write_accept lat=%0d count=%0d want 1/1", lat, count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (!pmem_write || pmem_address !== 32'h1000 || pmem_wdata !== d) begin
            errors++;
            $display("FAIL drain_start wr=%b addr=%h want 1/00001000",
                     pmem_write, pmem_address);
        end
        wait_drained(ok);
        checks++;
        if (!ok || retire() != 0 || wr_total - w0 != 1 || count !== 0) begin
            errors++;
            $display("FAIL drain_done ok=%b writes=%0d count=%0d want 1/1/0",
                     ok, wr_total - w0, count);
        end
    endtask

    task automatic test_full();
        line_t d;
        line_t d5 = rand_line();
        int    lat;
        int    lat5;
        int    bad = 0;
        int    w0 = wr_total;
        bit    ok;
        stall_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d = rand_line();
            cache_write(addr_t'(i * 32'h1000), d, lat);
            bad = model_write(addr_t'(i * 32'h1000), d);
            checks++;
            if (lat !== 1 || bad != 0) begin
                errors++;
                $display("FAIL fill_%0d lat=%0d want 1", i, lat);
            end
        end
        checks++;
        if (count !== 4) begin
            errors++;
            $display("FAIL full_count count=%0d want 4", count);
        end
        fork
            cache_write(32'h5000, d5, lat5);
            begin
                repeat (6) begin
                    @(posedge clk);
                    #1;
                end
                stall_wr = 1'b0;
            end
        join
        bad = retire();
        bad += model_write(32'h5000, d5);
        checks++;
        if (bad != 0 || lat5 <= 6 || count !== 4) begin
            errors++;
            $display("FAIL full_write bad=%0d lat=%0d count=%0d want 0/>6/4",
                     bad, lat5, count);
        end
        wait_drained(ok);
        bad = retire();
        checks++;
        if (!ok || bad != 0 || wr_total - w0 != 5) begin
            errors++;
            $display("FAIL full_order ok=%b bad=%0d writes=%0d want 1/0/5",
                     ok, bad, wr_total - w0);
        end
    endtask

    task automatic test_coalesce();
        line_t b = rand_line();
        line_t c = rand_line();
        int    lat;
        int    bad;
        int    w0 = wr_total;
        bit    ok;
        stall_wr = 1'b1;
        cache_write(32'h2000, b, lat);
        bad = model_write(32'h2000, b);
        cache_write(32'h2010, c, lat);
        bad += model_write(32'h2010, c);
        checks++;
        if (count !== 1 || lat !== 1 || bad != 0) begin
            errors++;
            $display("FAIL coalesce_count count=%0d lat=%0d want 1/1", count, lat);
        end
        stall_wr = 1'b0;
        wait_drained(ok);
        bad = retire();
        checks++;
        if (!ok || bad != 0 || wr_total - w0 != 1 || mem_store[32'h2000] !== c) begin
            errors++;
            $display("FAIL coalesce_drain ok=%b bad=%0d writes=%0d want 1/0/1",
                     ok, bad, wr_total - w0);
        end
    endtask

    task automatic test_read_hit();
        line_t d = rand_line();
        line_t got;
        int    lat;
        int    r0;
        stall_wr = 1'b1;
        cache_write(32'h3000, d, lat);
        void'(model_write(32'h3000, d));
        r0 = rd_total;
        cache_read(32'h3004, got, lat);
        checks++;
        if (got !== d || lat !== 1 || rd_total != r0) begin
            errors++;
            $display("FAIL read_hit got=%h lat=%0d memreads=%0d want %h/1/0",
                     got, lat, rd_total - r0, d);
        end
    endtask

    task automatic test_read_miss();
        line_t e = rand_line();
        line_t got;
        line_t exp;
        int    lat;
        int    w0;
        int    r0;
        int    bad;
        bit    ok;
        cache_write(32'h4000, e, lat);
        void'(model_write(32'h4000, e));
        checks++;
        if (count !== 2) begin
            errors++;
            $display("FAIL miss_setup count=%0d want 2", count);
        end
        mem_lat = $urandom_range(0, 3);
        w0  = wr_total;
        r0  = rd_total;
        exp = expected_read(32'h8000);
        cache_read(32'h8000, got, lat);
        checks++;
        if (got !== exp || lat !== mem_lat + 2 || wr_total != w0) begin
            errors++;
            $display("FAIL read_miss got=%h lat=%0d writes=%0d want %h/%0d/0",
                     got, lat, wr_total - w0, exp, mem_lat + 2);
        end
        stall_wr = 1'b0;
        wait_drained(ok);
        bad = retire();
        exp = expected_read(32'h3000);
        cache_read(32'h3000, got, lat);
        checks++;
        if (!ok || bad != 0 || got !== exp || rd_total - r0 != 2) begin
            errors++;
            $display("FAIL read_after_drain got=%h bad=%0d want %h/0", got, bad, exp);
        end
    endtask

    task automatic test_full_timing();
        line_t d;
        int    lat;
        int    bad = 0;
        bit    ok;
        stall_wr = 1'b0;
        mem_lat  = $urandom_range(0, 3);
        for (int i = 0; i < 5; i++) begin
            d = rand_line();
            cache_write(addr_t'(32'h9000 + i * 32'h100), d, lat);
            bad += retire();
            bad += model_write(addr_t'(32'h9000 + i * 32'h100), d);
        end
        checks++;
        if (lat !== mem_lat + 3 || bad != 0 || count !== 4) begin
            errors++;
            $display("FAIL full_timing lat=%0d bad=%0d count=%0d want %0d/0/4",
                     lat, bad, count, mem_lat + 3);
        end
        wait_drained(ok);
        bad = retire();
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL full_timing_drain ok=%b bad=%0d want 1/0", ok, bad);
        end
    endtask

    task automatic test_hit_during_drain();
        line_t e1 = rand_line();
        line_t e2 = rand_line();
        line_t got;
        int    lat;
        int    bad;
        int    n = 0;
        bit    ok;
        stall_wr = 1'b1;
        mem_lat  = 2;
        cache_write(32'h6000, e1, lat);
        void'(model_write(32'h6000, e1));
        while (!pmem_write && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!pmem_write || pmem_address !== 32'h6000) begin
            errors++;
            $display("FAIL hd_drain wr=%b addr=%h want 1/00006000",
                     pmem_write, pmem_address);
        end
        fork
            cache_write(32'h6000, e2, lat);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                stall_wr = 1'b0;
            end
        join
        bad = retire();
        bad += model_write(32'h6000, e2);
        checks++;
        if (bad != 0 || count !== 1) begin
            errors++;
            $display("FAIL hd_push bad=%0d count=%0d want 0/1", bad, count);
        end
        wait_drained(ok);
        bad = retire();
        got = mem_store.exists(32'h6000) ? mem_store[32'h6000] : '0;
        checks++;
        if (!ok || bad != 0 || got !== e2) begin
            errors++;
            $display("FAIL hd_newest mem=%h want %h", got, e2);
        end
    endtask

    task automatic test_random();
        addr_t a;
        line_t d;
        line_t got;
        line_t exp;
        int    lat;
        int    bad;
        int    r0;
        int    gap;
        bit    hit;
        bit    ok;
        stall_wr = 1'b0;
        for (int n = 0; n < 150; n++) begin
            mem_lat = $urandom_range(0, 2);
            a = addr_t'((32'h200 + $urandom_range(0, 7)) << OFFSET) |
                addr_t'($urandom_range(0, 31));
            bad = retire();
            if ($urandom_range(0, 2) == 0) begin
                r0 = rd_total;
                cache_read(a, got, lat);
                bad += retire();
                hit = model_has(a);
                exp = expected_read(a);
                checks++;
                if (lat < 0 || bad != 0 || got !== exp ||
                    rd_total - r0 != (hit ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rand_read_%0d a=%h got=%h want %h lat=%0d",
                             n, a, got, exp, lat);
                end
            end else begin
                d = rand_line();
                if (mq.size() == DEPTH && !model_has(a)) stall_wr = 1'b0;
                cache_write(a, d, lat);
                bad += retire();
                bad += model_write(a, d);
                checks++;
                if (lat < 0 || bad != 0 || int'(count) != mq.size()) begin
                    errors++;
                    $display("FAIL rand_write_%0d a=%h lat=%0d count=%0d want %0d",
                             n, a, lat, count, mq.size());
                end
            end
            gap = $urandom_range(0, 4);
            if (gap > 0) stall_wr = 1'b0;
            else if ($urandom_range(0, 3) == 0) stall_wr = 1'b1;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        stall_wr = 1'b0;
        wait_drained(ok);
        bad = retire();
        checks++;
        if (!ok || bad != 0 || mq.size() != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rand_final ok=%b bad=%0d left=%0d want 1/0/0",
                     ok, bad, mq.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int lat;
        int n = 0;
        stall_wr = 1'b1;
        cache_write(32'h7000, rand_line(), lat);
        while (!pmem_write && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre wr=%b want 1", pmem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || count !== 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid wr=%b count=%0d empty=%b want 0/0/1",
                     pmem_write, count, empty);
        end
        mq.delete();
        log_a.delete();
        log_d.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        stall_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count !== 0 || pmem_write !== 1'b0 || log_a.size() != 0) begin
            errors++;
            $display("FAIL rst_after count=%0d wr=%b logged=%0d want 0/0/0",
                     count, pmem_write, log_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_full();
        test_coalesce();
        test_read_hit();
        test_read_miss();
        test_full_timing();
        test_hit_during_drain();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
